up_dn_btn_conditioner: RTL
==========================

# up_dn_btn_conditioner

Input-conditioning stage that sits directly upstream of the 5-bit up/down counter. It takes three raw, asynchronous, bouncing pushbuttons (up, down, load) and produces clean single-cycle `up`, `down` and `load` command strobes in the CLK domain. It adds hold-to-repeat on up/down, and uses the counter's `high`/`low` flags to suppress strobes that would be ignored at the counter's saturation limits.

## Interface
Parameters:
- `DB_CYCLES`, default 1000: consecutive stable synchronized samples required to accept a level change; legal range ≥2.
- `DB_W`, default 10: debounce counter width; requires 2^DB_W > DB_CYCLES.
- `REP_DELAY`, default 500: cycles from the first strobe of a held up/down press to the first repeat strobe.
- `REP_PERIOD`, default 100: cycles between subsequent repeat strobes.
- `REP_W`, default 10: repeat counter width; requires 2^REP_W > max(REP_DELAY, REP_PERIOD).
- `REP_EN`, default 1: 0 disables auto-repeat.

Ports:
- `CLK` in 1: single clock; all state updates on rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `btn_up`, `btn_down`, `btn_load` in 1 each: raw asynchronous buttons, active-high.
- `high`, `low` in 1 each: counter saturation flags from the downstream counter.
- `up`, `down`, `load` out 1 each: registered single-cycle command strobes.
- `pressed` out 3: debounced levels {load, down, up}.

## Operation
- Each button has a 2-flop synchronizer (`s1`, `s2`), a `stable` level and a debounce counter `cnt`.
- Debounce, evaluated at each edge:
  - If `s2 == stable`: `cnt <= 0`.
  - Else if `cnt == DB_CYCLES-1`: `stable <= s2` and `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`.
  - Any sample that matches `stable` before acceptance restarts the count.
- A rising edge of `stable` produces a press event. A falling edge of `stable` produces no event.
- Up/down repeat FSM, one per channel, states IDLE, HOLD, REPEAT:
  - IDLE → HOLD on a press event; one strobe request; repeat counter cleared.
  - HOLD → REPEAT when the repeat counter reaches REP_DELAY-1; one strobe request; counter cleared.
  - REPEAT issues one strobe request each time the counter reaches REP_PERIOD-1, then clears the counter.
  - From HOLD or REPEAT: `stable` low → IDLE. REP_EN=0 means HOLD never advances.
- Load has no repeat. Each load press event is one request.
- Output arbitration, applied to the requests of the same cycle:
  - A load request wins; `up` and `down` are forced to 0 that cycle.
  - Simultaneous up and down requests cancel each other and neither is issued.
  - An up request is dropped while `high`=1; a down request is dropped while `low`=1.
  - The repeat FSM keeps running regardless; a dropped request is not queued.
- At most one of `up`, `down`, `load` is high in any cycle.

## Timing
- Reset:
  - `s1`, `s2`, `stable`, `cnt`, repeat counters, `up`, `down`, `load` and `pressed` = 0; FSMs = IDLE.
  - Takes effect at the first edge with `RST`=1 and has priority over all other updates.
  - A button already held when reset is released is debounced from 0 and yields one press strobe.
- Reset mid-debounce or mid-repeat discards all progress; no strobe is issued in the cycle after the reset edge.
- Press latency: if the raw input is high and steady from edge e0, then `stable` rises at edge e0+DB_CYCLES+1. The strobe is high for exactly one cycle, from that edge to the next.
- Release latency: the same DB_CYCLES+1 edges; `pressed` follows `stable`.
- Repeat strobes: press strobe at cycle P, then P+REP_DELAY, then P+REP_DELAY+k·REP_PERIOD.
- Counter widths do not wrap in legal configurations; counters are compared with `==`.

## Structure
- Shared package `up_dn_pkg`:
  - `rep_state_t` enum (IDLE, HOLD, REPEAT).
  - Default constants for DB_CYCLES and REP_DELAY/REP_PERIOD.
  - `CMD_W`=3 for the {load, down, up} bit order.
- Sub-module `btn_debounce`: synchronizer, debounce counter, `stable` level and rise pulse. Instantiated 3 times.
- The top level holds the two repeat FSMs and the output arbitration.

## Test plan
All scenarios use DB_CYCLES=4, REP_DELAY=8, REP_PERIOD=3.
- Clean press: `btn_up` held high from edge 0 → `up`=1 only in the cycle after edge 5; `pressed[0]`=1 from edge 5.
- Bounce: `btn_down` high for 3 cycles, low for 1, then high steadily → no strobe from the glitch; a single `down` strobe 5 edges after the steady high starts.
- Hold-repeat: `btn_up` held for 30 cycles with press strobe at cycle P → `up` strobes at P, P+8, P+11, P+14 and so on; stop within DB_CYCLES+1 edges of release.
- Saturation and arbitration:
  - `high`=1 with `btn_up` held → no `up` strobes.
  - `btn_up` and `btn_down` pressed at the same edge → no strobes.
  - `btn_load` pressed together with `btn_up` → `load` only.
- Reset mid-repeat: assert `RST` for one cycle during REPEAT → all outputs 0 at that edge; a held button yields a fresh press strobe 5 edges after `RST` deasserts.

Source files
------------

// File: rtl/up_dn_pkg.sv
// Shared types and constants for the up/down pushbutton conditioner.
// Command bit order everywhere is {load, down, up}.
package up_dn_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StRepeat
    } rep_state_t;

    localparam int unsigned DefDbCycles  = 1000;
    localparam int unsigned DefRepDelay  = 500;
    localparam int unsigned DefRepPeriod = 100;

    localparam int unsigned CMD_W   = 3;
    localparam int unsigned CmdUp   = 0;
    localparam int unsigned CmdDown = 1;
    localparam int unsigned CmdLoad = 2;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus counting debouncer for one raw pushbutton.
// rise_o is combinational so the press strobe can be registered on the same edge stable rises.
module btn_debounce
    import up_dn_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DefDbCycles,
    parameter int unsigned DB_W      = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic stable_o,
    output logic rise_o
);

    localparam logic [DB_W-1:0] DbMax = DB_W'(DB_CYCLES - 1);

    logic            s1_q;
    logic            s2_q;
    logic            stable_q;
    logic            stable_d;
    logic [DB_W-1:0] cnt_q;
    logic [DB_W-1:0] cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == DbMax) begin
            stable_d = s2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= btn_i;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = stable_d & ~stable_q;

endmodule

// File: rtl/up_dn_btn_conditioner.sv
// Debounces up/down/load buttons, adds hold-to-repeat on up/down, and arbitrates
// the resulting requests into single-cycle command strobes for the 5-bit counter.
module up_dn_btn_conditioner
    import up_dn_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = DefDbCycles,
    parameter int unsigned DB_W       = 10,
    parameter int unsigned REP_DELAY  = DefRepDelay,
    parameter int unsigned REP_PERIOD = DefRepPeriod,
    parameter int unsigned REP_W      = 10,
    parameter bit          REP_EN     = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_load,
    input  logic             high,
    input  logic             low,
    output logic             up,
    output logic             down,
    output logic             load,
    output logic [CMD_W-1:0] pressed
);

    localparam logic [REP_W-1:0] DelayMax  = REP_W'(REP_DELAY - 1);
    localparam logic [REP_W-1:0] PeriodMax = REP_W'(REP_PERIOD - 1);

    logic [CMD_W-1:0] stable;
    logic [CMD_W-1:0] rise;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .DB_W      (DB_W)
    ) u_db_up (
        .clk_i    (CLK),
        .rst_i    (RST),
        .btn_i    (btn_up),
        .stable_o (stable[CmdUp]),
        .rise_o   (rise[CmdUp])
    );

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .DB_W      (DB_W)
    ) u_db_down (
        .clk_i    (CLK),
        .rst_i    (RST),
        .btn_i    (btn_down),
        .stable_o (stable[CmdDown]),
        .rise_o   (rise[CmdDown])
    );

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .DB_W      (DB_W)
    ) u_db_load (
        .clk_i    (CLK),
        .rst_i    (RST),
        .btn_i    (btn_load),
        .stable_o (stable[CmdLoad]),
        .rise_o   (rise[CmdLoad])
    );

    // Repeat FSMs: index 0 is up, index 1 is down.
    rep_state_t       st_q [2];
    rep_state_t       st_d [2];
    logic [REP_W-1:0] rc_q [2];
    logic [REP_W-1:0] rc_d [2];
    logic [1:0]       rep_req;

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            st_d[c]    = st_q[c];
            rc_d[c]    = rc_q[c];
            rep_req[c] = 1'b0;
            unique case (st_q[c])
                StIdle: begin
                    if (rise[c]) begin
                        st_d[c]    = StHold;
                        rc_d[c]    = '0;
                        rep_req[c] = 1'b1;
                    end
                end
                StHold: begin
                    if (!stable[c]) begin
                        st_d[c] = StIdle;
                        rc_d[c] = '0;
                    end else if (REP_EN) begin
                        if (rc_q[c] == DelayMax) begin
                            st_d[c]    = StRepeat;
                            rc_d[c]    = '0;
                            rep_req[c] = 1'b1;
                        end else begin
                            rc_d[c] = rc_q[c] + 1'b1;
                        end
                    end
                end
                StRepeat: begin
                    if (!stable[c]) begin
                        st_d[c] = StIdle;
                        rc_d[c] = '0;
                    end else if (rc_q[c] == PeriodMax) begin
                        rc_d[c]    = '0;
                        rep_req[c] = 1'b1;
                    end else begin
                        rc_d[c] = rc_q[c] + 1'b1;
                    end
                end
                default: begin
                    st_d[c] = StIdle;
                    rc_d[c] = '0;
                end
            endcase
        end
    end

    // Load dominates; opposing up/down cancel; saturation drops the request outright.
    logic req_up;
    logic req_down;
    logic req_load;
    logic up_d;
    logic down_d;
    logic load_d;
    logic up_q;
    logic down_q;
    logic load_q;

    always_comb begin
        req_up   = rep_req[0];
        req_down = rep_req[1];
        req_load = rise[CmdLoad];
        load_d   = req_load;
        up_d     = req_up & ~req_down & ~req_load & ~high;
        down_d   = req_down & ~req_up & ~req_load & ~low;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int c = 0; c < 2; c++) begin
                st_q[c] <= StIdle;
                rc_q[c] <= '0;
            end
            up_q   <= 1'b0;
            down_q <= 1'b0;
            load_q <= 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                st_q[c] <= st_d[c];
                rc_q[c] <= rc_d[c];
            end
            up_q   <= up_d;
            down_q <= down_d;
            load_q <= load_d;
        end
    end

    assign up      = up_q;
    assign down    = down_q;
    assign load    = load_q;
    assign pressed = stable;

endmodule
